// File: rtl/ex_div_pkg.sv
// Shared defines for the M-extension divider: funct3 opcodes, result bundle
// and opcode decode helpers.
package ex_div_pkg;

  localparam logic [2:0] INST_DIV  = 3'b100;
  localparam logic [2:0] INST_DIVU = 3'b101;
  localparam logic [2:0] INST_REM  = 3'b110;
  localparam logic [2:0] INST_REMU = 3'b111;

  typedef struct packed {
    logic [31:0] result;
    logic        ready;
    logic [4:0]  reg_waddr;
  } DivResultBus;

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == INST_DIV) || (op == INST_REM);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == INST_DIV) || (op == INST_DIVU);
  endfunction

endpackage

// File: rtl/ex_div_if.sv
// Execute-stage <-> divider handshake bundle; execute is the master.
interface ex_div_if;

  logic        start_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [2:0]  op_i;
  logic [4:0]  reg_waddr_i;
  logic        flush_i;
  logic [31:0] result_o;
  logic        ready_o;
  logic        busy_o;
  logic [4:0]  reg_waddr_o;

  modport master (
    output start_i, dividend_i, divisor_i, op_i, reg_waddr_i, flush_i,
    input  result_o, ready_o, busy_o, reg_waddr_o
  );

  modport slave (
    input  start_i, dividend_i, divisor_i, op_i, reg_waddr_i, flush_i,
    output result_o, ready_o, busy_o, reg_waddr_o
  );

endinterface

// File: rtl/ex_div.sv
// Multi-cycle restoring radix-2 divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow short-circuit.
module ex_div
  import ex_div_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  ex_div_if.slave  bus
);

  localparam int DIV_ITERS = 32;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_CALC, ST_END} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic        signed_q;
  logic        div_sel_q;
  logic [31:0] dividend_q;
  logic [31:0] divisor_q;
  logic [4:0]  waddr_q;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvsr_q;
  logic        neg_quo;
  logic        neg_rem;

  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  DivResultBus res;

  always_comb begin
    a_neg = signed_q & dividend_q[31];
    b_neg = signed_q & divisor_q[31];
    a_mag = a_neg ? -dividend_q : dividend_q;
    b_mag = b_neg ? -divisor_q : divisor_q;
  end

  // Shift/subtract step: bit 32 of the difference set means the trial subtract went negative.
  always_comb begin
    shifted = {rem_q, quo_q[31]};
    diff    = shifted - {1'b0, dvsr_q};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      signed_q   <= 1'b0;
      div_sel_q  <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
      waddr_q    <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvsr_q     <= '0;
      neg_quo    <= 1'b0;
      neg_rem    <= 1'b0;
    end else if (state != ST_IDLE && bus.flush_i) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      signed_q   <= 1'b0;
      div_sel_q  <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvsr_q     <= '0;
      neg_quo    <= 1'b0;
      neg_rem    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start_i && !bus.flush_i) begin
            dividend_q <= bus.dividend_i;
            divisor_q  <= bus.divisor_i;
            signed_q   <= is_signed_op(bus.op_i);
            div_sel_q  <= is_div_op(bus.op_i);
            waddr_q    <= bus.reg_waddr_i;
            state      <= ST_START;
          end
        end
        ST_START: begin
          // Special results are final as loaded, so sign fix-up is disabled for them.
          if (divisor_q == '0) begin
            quo_q   <= 32'hFFFF_FFFF;
            rem_q   <= dividend_q;
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
            state   <= ST_END;
          end else if (signed_q && dividend_q == 32'h8000_0000 &&
                       divisor_q == 32'hFFFF_FFFF) begin
            quo_q   <= 32'h8000_0000;
            rem_q   <= '0;
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
            state   <= ST_END;
          end else begin
            quo_q   <= a_mag;
            dvsr_q  <= b_mag;
            rem_q   <= '0;
            cnt     <= '0;
            neg_quo <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            state   <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (!diff[32]) begin
            rem_q <= diff[31:0];
            quo_q <= {quo_q[30:0], 1'b1};
          end else begin
            rem_q <= shifted[31:0];
            quo_q <= {quo_q[30:0], 1'b0};
          end
          cnt <= cnt + 5'd1;
          if (cnt == 5'(DIV_ITERS - 1)) state <= ST_END;
        end
        ST_END: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs depend only on state registers and flush, never on operand inputs.
  always_comb begin
    quo_fix       = neg_quo ? -quo_q : quo_q;
    rem_fix       = neg_rem ? -rem_q : rem_q;
    res.ready     = (state == ST_END) && !bus.flush_i;
    res.result    = res.ready ? (div_sel_q ? quo_fix : rem_fix) : '0;
    res.reg_waddr = waddr_q;
  end

  assign bus.result_o    = res.result;
  assign bus.ready_o     = res.ready;
  assign bus.reg_waddr_o = res.reg_waddr;
  assign bus.busy_o      = (state != ST_IDLE);

endmodule

// File: tb/tb_ex_div.sv
// Directed bench for ex_div: vector table for latency/results plus hand
// sequences for flush, held start and mid-operation reset.
module tb_ex_div;
  import ex_div_pkg::*;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  waddr;
    logic [31:0] expResult;
    int          expLatency;
    string       name;
  } DivVector;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int compared = 0;
  int mismatched = 0;
  DivVector vectors[$];

  ex_div_if bus();

  ex_div dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drives start for exactly one sampling edge, returning #1 after it.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] wa);
    bus.start_i     = 1'b1;
    bus.op_i        = op;
    bus.dividend_i  = a;
    bus.divisor_i   = b;
    bus.reg_waddr_i = wa;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
  endtask

  task automatic waitReady(output int latency, output logic [31:0] result,
                           output logic [4:0] waddr, output int busyDrops,
                           output int strayResults);
    latency = 999;
    result = '0;
    waddr = '0;
    busyDrops = 0;
    strayResults = 0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      if (!bus.busy_o) busyDrops++;
      if (bus.ready_o) begin
        latency = cyc;
        result = bus.result_o;
        waddr = bus.reg_waddr_o;
        break;
      end
      if (bus.result_o != 32'd0) strayResults++;
    end
  endtask

  task automatic runVector(input DivVector v);
    int lat;
    logic [31:0] res;
    logic [4:0] wa;
    int drops;
    int strays;
    @(negedge clk);
    applyStimulus(v.op, v.a, v.b, v.waddr);
    waitReady(lat, res, wa, drops, strays);
    checkOutput({v.name, " result"}, res, v.expResult);
    checkOutput({v.name, " latency"}, 32'(lat), 32'(v.expLatency));
    checkOutput({v.name, " waddr"}, 32'(wa), 32'(v.waddr));
    checkOutput({v.name, " busy drops"}, 32'(drops), 32'd0);
    checkOutput({v.name, " stray result"}, 32'(strays), 32'd0);
    @(negedge clk);
    checkOutput({v.name, " idle busy"}, 32'(bus.busy_o), 32'd0);
    checkOutput({v.name, " idle ready"}, 32'(bus.ready_o), 32'd0);
  endtask

  initial begin
    int lat;
    logic [31:0] res;
    logic [4:0] wa;
    int drops;
    int strays;
    int readySeen;
    int waddrBad;
    int readyCyc;
    logic [31:0] heldRes;
    logic busyAt35;

    bus.start_i     = 1'b0;
    bus.flush_i     = 1'b0;
    bus.op_i        = '0;
    bus.dividend_i  = '0;
    bus.divisor_i   = '0;
    bus.reg_waddr_i = '0;

    repeat (2) @(negedge clk);
    checkOutput("reset result", bus.result_o, 32'd0);
    checkOutput("reset ready", 32'(bus.ready_o), 32'd0);
    checkOutput("reset busy", 32'(bus.busy_o), 32'd0);
    checkOutput("reset waddr", 32'(bus.reg_waddr_o), 32'd0);
    rst = 1'b1;

    vectors.push_back('{INST_DIVU, 32'd100,        32'd7,        5'd1,  32'd14,        34, "DIVU 100/7"});
    vectors.push_back('{INST_REMU, 32'd100,        32'd7,        5'd2,  32'd2,         34, "REMU 100/7"});
    vectors.push_back('{INST_REM,  32'hFFFF_FFF9,  32'd2,        5'd3,  32'hFFFF_FFFF, 34, "REM -7/2"});
    vectors.push_back('{INST_DIV,  32'hFFFF_FFF9,  32'd2,        5'd4,  32'hFFFF_FFFD, 34, "DIV -7/2"});
    vectors.push_back('{INST_DIV,  32'd20,         32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFFA, 34, "DIV 20/-3"});
    vectors.push_back('{INST_REM,  32'hFFFF_FFEC,  32'hFFFF_FFFD, 5'd6, 32'hFFFF_FFFE, 34, "REM -20/-3"});
    vectors.push_back('{INST_DIV,  32'hFFFF_FFEC,  32'hFFFF_FFFD, 5'd7, 32'd6,         34, "DIV -20/-3"});
    vectors.push_back('{INST_DIV,  32'd5,          32'd0,        5'd8,  32'hFFFF_FFFF, 2,  "DIV 5/0"});
    vectors.push_back('{INST_REMU, 32'd5,          32'd0,        5'd9,  32'd5,         2,  "REMU 5/0"});
    vectors.push_back('{INST_DIV,  32'hFFFF_FFF9,  32'd0,        5'd10, 32'hFFFF_FFFF, 2,  "DIV -7/0"});
    vectors.push_back('{INST_REM,  32'hFFFF_FFF9,  32'd0,        5'd11, 32'hFFFF_FFF9, 2,  "REM -7/0"});
    vectors.push_back('{INST_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 2, "DIV ovf"});
    vectors.push_back('{INST_REM,  32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 32'd0,        2,  "REM ovf"});
    vectors.push_back('{INST_DIVU, 32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 32'd0,        34, "DIVU big/max"});
    vectors.push_back('{INST_DIVU, 32'hFFFF_FFFF,  32'd1,        5'd15, 32'hFFFF_FFFF, 34, "DIVU max/1"});

    foreach (vectors[i]) runVector(vectors[i]);

    // Flush during CALC, then a new op right in the recovery cycle.
    @(negedge clk);
    applyStimulus(INST_DIVU, 32'd1000, 32'd3, 5'd20);
    readySeen = 0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (bus.ready_o) readySeen++;
    end
    bus.flush_i = 1'b1;
    #1;
    checkOutput("flush calc ready", 32'(bus.ready_o), 32'd0);
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    @(negedge clk);
    checkOutput("flush idle busy", 32'(bus.busy_o), 32'd0);
    checkOutput("flush ready seen", 32'(readySeen), 32'd0);
    applyStimulus(INST_DIVU, 32'd9, 32'd3, 5'd21);
    waitReady(lat, res, wa, drops, strays);
    checkOutput("post-flush result", res, 32'd3);
    checkOutput("post-flush latency", 32'(lat), 32'd34);
    checkOutput("post-flush waddr", 32'(wa), 32'd21);

    // Flush landing on the END cycle must gate ready and result.
    @(negedge clk);
    applyStimulus(INST_DIV, 32'd5, 32'd0, 5'd22);
    @(negedge clk);
    @(negedge clk);
    checkOutput("end pre-flush ready", 32'(bus.ready_o), 32'd1);
    bus.flush_i = 1'b1;
    #1;
    checkOutput("end flush ready", 32'(bus.ready_o), 32'd0);
    checkOutput("end flush result", bus.result_o, 32'd0);
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    @(negedge clk);
    checkOutput("end flush busy", 32'(bus.busy_o), 32'd0);

    // Flush in IDLE suppresses a simultaneous start.
    @(negedge clk);
    bus.flush_i = 1'b1;
    applyStimulus(INST_DIVU, 32'd8, 32'd2, 5'd23);
    bus.flush_i = 1'b0;
    @(negedge clk);
    checkOutput("idle flush busy", 32'(bus.busy_o), 32'd0);

    // Start held high: second op captured only once IDLE is reached again.
    @(negedge clk);
    bus.start_i     = 1'b1;
    bus.op_i        = INST_DIVU;
    bus.dividend_i  = 32'd100;
    bus.divisor_i   = 32'd7;
    bus.reg_waddr_i = 5'd5;
    @(posedge clk);
    #1;
    bus.dividend_i  = 32'd50;
    bus.divisor_i   = 32'd5;
    bus.reg_waddr_i = 5'd9;
    waddrBad = 0;
    readyCyc = 0;
    heldRes  = '0;
    busyAt35 = 1'b1;
    for (int cyc = 1; cyc <= 35; cyc++) begin
      @(negedge clk);
      if (bus.reg_waddr_o != 5'd5) waddrBad++;
      if (bus.ready_o) begin
        readyCyc = cyc;
        heldRes = bus.result_o;
      end
      if (cyc == 35) busyAt35 = bus.busy_o;
    end
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    checkOutput("held waddr stable", 32'(waddrBad), 32'd0);
    checkOutput("held ready cycle", 32'(readyCyc), 32'd34);
    checkOutput("held result", heldRes, 32'd14);
    checkOutput("held busy cycle35", 32'(busyAt35), 32'd0);
    waitReady(lat, res, wa, drops, strays);
    checkOutput("held second result", res, 32'd10);
    checkOutput("held second latency", 32'(lat), 32'd34);
    checkOutput("held second waddr", 32'(wa), 32'd9);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    applyStimulus(INST_DIVU, 32'd1000, 32'd7, 5'd6);
    repeat (20) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midrst result", bus.result_o, 32'd0);
    checkOutput("midrst ready", 32'(bus.ready_o), 32'd0);
    checkOutput("midrst busy", 32'(bus.busy_o), 32'd0);
    checkOutput("midrst waddr", 32'(bus.reg_waddr_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("post-rst busy", 32'(bus.busy_o), 32'd0);
    runVector('{INST_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd17, 32'hFFFF_FFFF, 34, "post-rst DIVU"});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ex_div.md
# ex_div

Multi-cycle 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU instructions. It sits directly downstream of the ID/EX pipeline register, beside the execute stage. Execute passes it the operands and destination register of a divide instruction and holds the pipeline while `busy_o` is high. On completion, execute writes `result_o` back to `reg_waddr_o` in the cycle `ready_o` pulses.

## Interface
Parameters:
- none; the datapath is fixed at 32 bits, and the iteration count of 32 is a localparam.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; one clock, asynchronous assert, active-low.
- `start_i`  in  1  request a divide; sampled only in IDLE.
- `dividend_i`  in  32  rs1 value.
- `divisor_i`  in  32  rs2 value.
- `op_i`  in  3  funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `reg_waddr_i`  in  5  destination register.
- `flush_i`  in  1  abort the operation in flight (jump or interrupt).
- `result_o`  out  32  quotient or remainder; valid only while `ready_o`=1, otherwise 0.
- `ready_o`  out  1  one-cycle completion pulse.
- `busy_o`  out  1  high in every state except IDLE.
- `reg_waddr_o`  out  5  captured destination register; held until the next start.

## Operation
- States: IDLE, START, CALC, END.
- IDLE:
  - On `start_i`=1 and `flush_i`=0, capture the operands, op and waddr, then go to START.
  - `start_i` is ignored in every other state.
- START:
  - Special case, divisor==0: quotient = 0xFFFFFFFF and remainder = dividend (signed and unsigned). Go to END.
  - Special case, signed overflow (DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF): quotient = 0x80000000, remainder = 0. Go to END.
  - Otherwise take the operand magnitudes (signed ops only), clear the 32-bit remainder, load the dividend shift register, clear the counter, and go to CALC.
- CALC:
  - Restoring radix-2, one quotient bit per cycle.
  - Per cycle: shift the remainder left, inserting the dividend MSB, and subtract the divisor magnitude with a 33-bit subtract.
  - If the result is non-negative, keep the difference and the quotient bit is 1; else the quotient bit is 0.
  - After 32 iterations (counter 0..31) go to END.
- END:
  - Apply signs: negate the quotient if the operand signs differ (signed ops); negate the remainder if the dividend is negative (signed ops).
  - Drive `result_o` with the quotient (DIV/DIVU) or the remainder (REM/REMU), and pulse `ready_o`=1.
  - Return to IDLE unconditionally.
- `flush_i`=1 in START, CALC or END:
  - Next state is IDLE and internal registers clear.
  - `ready_o` does not pulse in that cycle; the END-state output is gated by `!flush_i`.
- `flush_i` in IDLE suppresses capture of a simultaneous `start_i`.
- Reset mid-operation: immediately IDLE, all outputs 0, counter 0.

## Timing
- Reset values: `result_o`=0, `ready_o`=0, `busy_o`=0, `reg_waddr_o`=0, state IDLE.
- Normal divide latency:
  - `start_i` high in cycle 0 (IDLE).
  - Cycle 1 is START, cycles 2–33 are CALC, cycle 34 is END with `ready_o`=1.
  - IDLE in cycle 35; a new `start_i` is accepted in cycle 35 at the earliest.
- Special-case latency: START in cycle 1, END with `ready_o`=1 in cycle 2.
- `busy_o` is high from cycle 1 through the END cycle inclusive. It is registered (state-derived) with no combinational path from `start_i`.
- `result_o` and `ready_o` are combinational from the state registers and `flush_i` only. No path exists from operand inputs to outputs.

## Structure
- Opcode constants live in the shared defines header, reusing the existing M-extension funct3 defines (`INST_DIV`, `INST_DIVU`, `INST_REM`, `INST_REMU`).
- Add `DivResultBus` there.
- State encoding stays local (localparam, 4 one-hot or 2-bit binary).
- Single flat module; no sub-module. The subtract/shift step is one always block.

## Test plan
- DIVU 100/7: `start_i` in cycle 0 → `ready_o` in cycle 34, `result_o`=14, `busy_o` high in cycles 1–34.
- REM with dividend -7 (0xFFFFFFF9) and divisor 2 → `result_o`=0xFFFFFFFF (-1). DIV on the same operands → 0xFFFFFFFD (-3).
- DIV 5/0 → `ready_o` in cycle 2, `result_o`=0xFFFFFFFF. REMU 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM on the same operands → 0.
- `flush_i` pulsed in cycle 10 of a DIVU → IDLE in cycle 11, `ready_o` never asserted. A new DIVU 9/3 started in cycle 11 → `ready_o` in cycle 45 with `result_o`=3.
- `start_i` held high through a full op → a second op is captured only in cycle 35; `reg_waddr_o` changes only at that capture.
- `rst` asserted in cycle 20 of an op → all outputs 0 immediately; after release, DIVU 0xFFFFFFFF/1 completes with `result_o`=0xFFFFFFFF.
